bwt_rle_encoder: RTL and testbench
==================================

Name: bwt_rle_encoder

Overview:
- Downstream stage of the BWT sorter. Captures the completed BWT string (parallel byte array plus `done` pulse) and emits it as a stream of (symbol, run-length) pairs over a valid/ready handshake.
- Feeds the entropy/packing stage.
- Scans one byte per cycle; holds a single registered output pair.

Parameters:
- STRING_LEN, 32, number of bytes in the BWT string; must match the sorter.
- MAX_RUN, 255, maximum run length per emitted pair; legal range 1..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- bwt_string  input  8 x STRING_LEN (unpacked [STRING_LEN-1:0])  BWT output bytes, index 0 first
- bwt_valid  input  1  one-cycle pulse; bwt_string is valid this cycle (sorter `done`)
- busy  output  1  high from capture until the DONE state exits
- out_valid  output  1  pair available
- out_ready  input  1  consumer accepts the pair
- out_symbol  output  8  run symbol
- out_run  output  8  run length, 1..MAX_RUN
- out_last  output  1  marks the final pair of the string
- done  output  1  one-cycle pulse after the last pair is accepted

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, out_valid, out_last, done = 0.
  - out_symbol, out_run = 0; internal buffer, index and run counter cleared.
  - Reset mid-operation aborts immediately; the partial stream is discarded and no done pulse is produced.
- All outputs are registered. idx width is $clog2(STRING_LEN+1).
- IDLE:
  - On bwt_valid=1: copy bwt_string into buf; sym=buf[0]; run=1; idx=1; busy=1; go to SCAN.
  - bwt_valid while not IDLE is ignored; the buffer stays untouched.
- SCAN (one comparison per cycle):
  - If idx==STRING_LEN: load the output pair with last=1; go to EMIT.
  - Else if buf[idx]==sym and run<MAX_RUN: run++, idx++; stay in SCAN.
  - Else: load the output pair with last=0; go to EMIT. idx is not advanced.
  - Loading the pair sets out_symbol=sym, out_run=run, out_last=last, out_valid=1, all registered.
- EMIT:
  - Hold out_valid=1 and keep out_symbol/out_run/out_last stable until out_valid && out_ready.
  - On transfer with out_last=1: out_valid=0; go to DONE.
  - On transfer with out_last=0: out_valid=0; sym=buf[idx]; run=1; idx++; go to SCAN.
  - out_ready is ignored while out_valid=0.
- DONE: done=1 for exactly one cycle; busy=0 next cycle; go to IDLE.
- Latency with out_ready held high:
  - Pairs emitted = P; total cycles from bwt_valid to done = STRING_LEN + P + 1.
  - The first pair's out_valid rises at the earliest 2 cycles after bwt_valid.
- Run rules:
  - Runs saturate at MAX_RUN; an equal symbol continues in a fresh pair.
  - The sum of all out_run values always equals STRING_LEN.
  - Exactly one pair per string has out_last=1.

Optional Feature:
- Macro: BWT_RLE_STATS_EN.
- When defined:
  - Adds output pair_count, 8 bits.
  - Cleared on capture; incremented on each accepted pair.
  - Held after done until the next capture; reset to 0.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package bwt_pkg holds:
  - SYM_W=8 and RUN_W=8.
  - The rle_state_t enum {IDLE, SCAN, EMIT, DONE}.
  - A packed struct rle_pair_t {symbol, run, last} used by this block and the downstream packer.
- No sub-module; the scan, buffer and output register stay in one module.

Test Plan:
- All 32 bytes 'a' (0x61), MAX_RUN=255, ready=1 → one pair (0x61, 32, last=1); done 34 cycles after bwt_valid.
- All 32 bytes 'a', MAX_RUN=8 → four pairs (0x61, 8); last=1 only on the fourth; pair_count=4 when stats are enabled.
- Alternating 0x41/0x42 → 32 pairs, each run=1, symbols alternating; total 65 cycles to done.
- String "aaabbbbc" plus 24×'d' with out_ready low for 5 cycles during the first EMIT → out_symbol=0x61 and out_run=3 held stable; then (62,4), (63,1), (64,24, last).
- Second bwt_valid pulse during SCAN with different data → ignored; the stream matches the first string.
- rst_n asserted during EMIT → out_valid=0, busy=0 asynchronously; after release a new bwt_valid produces a complete, correct stream.

Source files
------------

// File: rtl/bwt_pkg.sv
// Shared definitions for the BWT pipeline (sorter -> RLE encoder -> packer).
//   SYM_W / RUN_W : widths of a run symbol and of a run length
//   rle_state_t   : RLE encoder control states
//   rle_pair_t    : one (symbol, run, last) pair as handed to the packer
package bwt_pkg;

  localparam int SYM_W = 8;
  localparam int RUN_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } rle_state_t;

  typedef struct packed {
    logic [SYM_W-1:0] symbol;
    logic [RUN_W-1:0] run;
    logic             last;
  } rle_pair_t;

endpackage

// File: rtl/bwt_rle_encoder.sv
// Run-length encoder for a completed BWT string.
// Captures the parallel byte array on bwt_valid, scans it one byte per cycle
// and emits (symbol, run) pairs over a valid/ready handshake.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bwt_string        STRING_LEN bytes from the sorter, index 0 first
//   bwt_valid         one-cycle capture pulse (ignored unless idle)
//   busy              high from capture until the DONE state exits
//   out_valid/ready   pair handshake
//   out_symbol/run    current pair, run in 1..MAX_RUN
//   out_last          marks the final pair of the string
//   done              one-cycle pulse after the last pair is accepted
//   pair_count        (only with BWT_RLE_STATS_EN) accepted pairs since capture
// Optional feature macro: BWT_RLE_STATS_EN
module bwt_rle_encoder
  import bwt_pkg::*;
#(
  parameter int STRING_LEN = 32,
  parameter int MAX_RUN    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SYM_W-1:0] bwt_string [STRING_LEN-1:0],
  input  logic             bwt_valid,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_symbol,
  output logic [RUN_W-1:0] out_run,
  output logic             out_last,
`ifdef BWT_RLE_STATS_EN
  output logic [7:0]       pair_count,
`endif
  output logic             done
);

  localparam int IDX_W  = $clog2(STRING_LEN + 1);
  localparam int RD_W   = (STRING_LEN > 1) ? $clog2(STRING_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STRING_LEN);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_RUN);

  rle_state_t       state;
  logic [SYM_W-1:0] str_buf [STRING_LEN-1:0];
  logic [SYM_W-1:0] sym;
  logic [RUN_W-1:0] run;
  logic [IDX_W-1:0] idx;
  logic [RD_W-1:0]  rd_idx;
  rle_pair_t        pair_q;

  // idx reaches STRING_LEN only as the end marker; the buffer is never read then.
  assign rd_idx = idx[RD_W-1:0];

  assign out_symbol = pair_q.symbol;
  assign out_run    = pair_q.run;
  assign out_last   = pair_q.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      pair_q    <= '0;
      sym       <= '0;
      run       <= '0;
      idx       <= '0;
      for (int unsigned i = 0; i < STRING_LEN; i++) str_buf[i] <= '0;
`ifdef BWT_RLE_STATS_EN
      pair_count <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bwt_valid) begin
            str_buf <= bwt_string;
            sym     <= bwt_string[0];
            run     <= RUN_W'(1);
            idx     <= IDX_W'(1);
            busy    <= 1'b1;
            state   <= SCAN;
`ifdef BWT_RLE_STATS_EN
            pair_count <= '0;
`endif
          end
        end
        SCAN: begin
          if (idx == LAST_IDX) begin
            pair_q    <= '{symbol: sym, run: run, last: 1'b1};
            out_valid <= 1'b1;
            state     <= EMIT;
          end else if (str_buf[rd_idx] == sym && run < RUN_MAX) begin
            run <= run + RUN_W'(1);
            idx <= idx + IDX_W'(1);
          end else begin
            // idx stays put: the breaking byte seeds the next run after EMIT.
            pair_q    <= '{symbol: sym, run: run, last: 1'b0};
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef BWT_RLE_STATS_EN
            pair_count <= pair_count + 8'd1;
`endif
            if (pair_q.last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              sym   <= str_buf[rd_idx];
              run   <= RUN_W'(1);
              idx   <= idx + IDX_W'(1);
              state <= SCAN;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bwt_rle_encoder.sv
// Self-checking bench for bwt_rle_encoder. Two instances (MAX_RUN 255 and 8)
// share the stimulus; a run-splitting model predicts each instance's pairs.
module tb_bwt_rle_encoder;

  localparam int L = 32;

  typedef struct {
    int sym;
    int run;
    int last;
  } pair_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bwt_string [L-1:0];
  logic [7:0] model_str  [L-1:0];
  logic       bwt_valid = 1'b0;
  logic       out_ready;
  logic       busy [2];
  logic       out_valid [2];
  logic [7:0] out_symbol [2];
  logic [7:0] out_run [2];
  logic       out_last [2];
  logic       done [2];
`ifdef BWT_RLE_STATS_EN
  logic [7:0] pair_count [2];
`endif

  int rmode = 0;          // 0: ready high, 1: random ready, 2: man_ready
  logic rnd_ready = 1'b1;
  logic man_ready = 1'b1;
  assign out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? rnd_ready : man_ready;

  int checks = 0;
  int errors = 0;
  int cycnt = 0;

  pair_t q0[$], q1[$], obs0[$], obs1[$];
  int start_c [2];
  int exp_lat [2];
  int npairs [2];
  int lat_obs [2];
  int done_cnt [2];
  bit ready_hi [2];
  bit prev_done [2];

  always #5 clk = ~clk;
  always @(posedge clk) cycnt++;
  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  bwt_rle_encoder #(.STRING_LEN(L), .MAX_RUN(255)) dut (
    .clk(clk), .rst_n(rst_n), .bwt_string(bwt_string), .bwt_valid(bwt_valid),
    .busy(busy[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_symbol(out_symbol[0]), .out_run(out_run[0]), .out_last(out_last[0]),
`ifdef BWT_RLE_STATS_EN
    .pair_count(pair_count[0]),
`endif
    .done(done[0]));

  bwt_rle_encoder #(.STRING_LEN(L), .MAX_RUN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bwt_string(bwt_string), .bwt_valid(bwt_valid),
    .busy(busy[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_symbol(out_symbol[1]), .out_run(out_run[1]), .out_last(out_last[1]),
`ifdef BWT_RLE_STATS_EN
    .pair_count(pair_count[1]),
`endif
    .done(done[1]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Split every maximal run of equal bytes into MAX_RUN-sized chunks.
  task automatic model_load();
    for (int inst = 0; inst < 2; inst++) begin
      int maxr;
      int i;
      int cnt;
      maxr = (inst == 0) ? 255 : 8;
      i = 0;
      cnt = 0;
      while (i < L) begin
        int j;
        int n;
        j = i;
        while (j < L && model_str[j] == model_str[i]) j++;
        n = j - i;
        while (n > 0) begin
          pair_t p;
          p.sym  = model_str[i];
          p.run  = (n > maxr) ? maxr : n;
          p.last = (j == L && n == p.run) ? 1 : 0;
          n -= p.run;
          cnt++;
          if (inst == 0) q0.push_back(p); else q1.push_back(p);
        end
        i = j;
      end
      npairs[inst]  = cnt;
      exp_lat[inst] = L + cnt + 1;
      start_c[inst] = cycnt;
      ready_hi[inst] = (rmode == 0);
    end
  endtask

  task automatic check_inst(input int i);
    pair_t e;
    int qs;
    qs = (i == 0) ? q0.size() : q1.size();
    if (out_valid[i]) begin
      if (qs == 0) begin
        chk($sformatf("unexpected_pair%0d", i), 1, 0);
      end else begin
        e = (i == 0) ? q0[0] : q1[0];
        chk($sformatf("symbol%0d", i), out_symbol[i], e.sym);
        chk($sformatf("run%0d", i), out_run[i], e.run);
        chk($sformatf("last%0d", i), out_last[i], e.last);
        if (out_ready) begin
          pair_t o;
          o.sym = out_symbol[i]; o.run = out_run[i]; o.last = out_last[i];
          if (i == 0) begin void'(q0.pop_front()); obs0.push_back(o); end
          else begin void'(q1.pop_front()); obs1.push_back(o); end
        end
      end
    end
    if (done[i]) begin
      chk($sformatf("done_all_pairs%0d", i), qs, 0);
      chk($sformatf("done_one_cycle%0d", i), prev_done[i], 0);
      lat_obs[i] = cycnt - start_c[i];
      if (ready_hi[i]) chk($sformatf("latency%0d", i), lat_obs[i], exp_lat[i]);
`ifdef BWT_RLE_STATS_EN
      chk($sformatf("pair_count%0d", i), pair_count[i], npairs[i]);
`endif
      done_cnt[i]++;
    end
    prev_done[i] = done[i];
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_inst(0);
      check_inst(1);
    end
  end

  task automatic pulse_valid(input bit load_model);
    @(posedge clk);
    #1;
    bwt_string = model_str;
    bwt_valid = 1'b1;
    if (load_model) model_load();
    @(posedge clk);
    #1;
    bwt_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t0, t1;
    int n;
    t0 = done_cnt[0] + 1;
    t1 = done_cnt[1] + 1;
    n = 0;
    while ((done_cnt[0] < t0 || done_cnt[1] < t1) && n < 800) begin
      @(posedge clk);
      n++;
    end
    chk("done_timeout", (n < 800) ? 1 : 0, 1);
    @(posedge clk);
  endtask

  task automatic check_obs0(input int idx, input int sym, input int run, input int last);
    if (idx < obs0.size()) begin
      chk($sformatf("lit_sym[%0d]", idx), obs0[idx].sym, sym);
      chk($sformatf("lit_run[%0d]", idx), obs0[idx].run, run);
      chk($sformatf("lit_last[%0d]", idx), obs0[idx].last, last);
    end else begin
      chk($sformatf("lit_missing[%0d]", idx), obs0.size(), idx + 1);
    end
  endtask

  initial begin
    for (int k = 0; k < L; k++) model_str[k] = 8'h00;
    bwt_string = model_str;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", busy[i], 0);
      chk("rst_valid", out_valid[i], 0);
      chk("rst_last", out_last[i], 0);
      chk("rst_done", done[i], 0);
      chk("rst_symbol", out_symbol[i], 0);
      chk("rst_run", out_run[i], 0);
    end
    #3 rst_n = 1'b1;

    // All 'a': one pair of 32 on the wide instance, four of 8 on dut8.
    rmode = 0;
    obs0.delete(); obs1.delete();
    for (int k = 0; k < L; k++) model_str[k] = 8'h61;
    pulse_valid(1);
    wait_done();
    check_obs0(0, 8'h61, 32, 1);
    chk("lit_lat_all_a", lat_obs[0], 34);
    chk("lit_pairs_max8", obs1.size(), 4);
    if (obs1.size() == 4) begin
      chk("lit_max8_run", obs1[3].run, 8);
      chk("lit_max8_last3", obs1[3].last, 1);
      chk("lit_max8_last2", obs1[2].last, 0);
    end

    // Alternating symbols: 32 single-byte pairs.
    obs0.delete(); obs1.delete();
    for (int k = 0; k < L; k++) model_str[k] = (k % 2 == 0) ? 8'h41 : 8'h42;
    pulse_valid(1);
    wait_done();
    chk("lit_alt_pairs", obs0.size(), 32);
    chk("lit_lat_alt", lat_obs[0], 65);

    // Stall the first pair for 5 cycles; it must stay frozen.
    obs0.delete(); obs1.delete();
    for (int k = 0; k < L; k++)
      model_str[k] = (k < 3) ? 8'h61 : (k < 7) ? 8'h62 : (k == 7) ? 8'h63 : 8'h64;
    man_ready = 1'b0;
    rmode = 2;
    pulse_valid(1);
    for (int n = 0; n < 50 && !out_valid[0]; n++) @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("stall_valid", out_valid[0], 1);
      chk("stall_symbol", out_symbol[0], 8'h61);
      chk("stall_run", out_run[0], 3);
    end
    man_ready = 1'b1;
    wait_done();
    check_obs0(0, 8'h61, 3, 0);
    check_obs0(1, 8'h62, 4, 0);
    check_obs0(2, 8'h63, 1, 0);
    check_obs0(3, 8'h64, 24, 1);
    rmode = 0;

    // A second bwt_valid while scanning must be ignored.
    for (int k = 0; k < L; k++) model_str[k] = 8'h70 + 8'(k / 5);
    pulse_valid(1);
    repeat (2) @(posedge clk);
    for (int k = 0; k < L; k++) model_str[k] = 8'hEE - 8'(k % 3);
    pulse_valid(0);
    wait_done();

    // Asynchronous reset while a pair is waiting in EMIT.
    for (int k = 0; k < L; k++) model_str[k] = 8'($urandom_range(1, 3));
    man_ready = 1'b0;
    rmode = 2;
    pulse_valid(1);
    for (int n = 0; n < 50 && !out_valid[0]; n++) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_valid", out_valid[i], 0);
      chk("arst_busy", busy[i], 0);
      chk("arst_done", done[i], 0);
    end
    q0.delete(); q1.delete();
    prev_done[0] = 0; prev_done[1] = 0;
    #7 rst_n = 1'b1;
    rmode = 0;
    man_ready = 1'b1;
    for (int k = 0; k < L; k++) model_str[k] = 8'($urandom_range(8'h30, 8'h32));
    pulse_valid(1);
    wait_done();

    // Randomized strings with a small alphabet and random backpressure.
    for (int t = 0; t < 20; t++) begin
      int alpha;
      alpha = $urandom_range(1, 4);
      for (int k = 0; k < L; k++) model_str[k] = 8'($urandom_range(0, alpha - 1)) + 8'h50;
      rmode = $urandom_range(0, 1);
      pulse_valid(1);
      wait_done();
    end
    rmode = 0;
    chk("final_q0_empty", q0.size(), 0);
    chk("final_q1_empty", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
